// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux lane; owns the select and registers the chosen word.
// Optional burst limit: define MUX2X1_ARB_BURST_LIMIT_EN to cap a grant at MAX_HOLD transfers while the other side waits.
module mux2x1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sel;
    logic             r_last;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic             w_xfer;
    logic             w_burst_switch;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux2x1_arbiter: MAX_HOLD must be in 1..255");
    end

    assign w_xfer = ((r_state == GRANT0) && req0) || ((r_state == GRANT1) && req1);

`ifdef MUX2X1_ARB_BURST_LIMIT_EN
    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold_cnt;

    // The last allowed transfer of a grant hands over on the same edge, so no dead cycle.
    assign w_burst_switch = w_xfer && (r_hold_cnt == HOLD_LAST) &&
                            ((r_state == GRANT0) ? req1 : req0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if ((w_next_state != r_state) || (w_next_state == IDLE)) begin
            r_hold_cnt <= '0;
        end else if (w_xfer) begin
            r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? '0 : r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_burst_switch = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_next_state = r_last ? GRANT0 : GRANT1;
                end else if (req0) begin
                    w_next_state = GRANT0;
                end else if (req1) begin
                    w_next_state = GRANT1;
                end
            end
            GRANT0: begin
                if (!req0) begin
                    w_next_state = req1 ? GRANT1 : IDLE;
                end else if (w_burst_switch) begin
                    w_next_state = GRANT1;
                end
            end
            GRANT1: begin
                if (!req1) begin
                    w_next_state = req0 ? GRANT0 : IDLE;
                end else if (w_burst_switch) begin
                    w_next_state = GRANT0;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_last    <= 1'b1;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Select and last-owner only move on grant entry; IDLE keeps the previous select.
            if (w_next_state == GRANT0) begin
                r_sel  <= 1'b0;
                r_last <= 1'b0;
            end else if (w_next_state == GRANT1) begin
                r_sel  <= 1'b1;
                r_last <= 1'b1;
            end
            r_y_valid <= w_xfer;
            if (w_xfer) begin
                r_y <= r_sel ? d1 : d0;
            end
        end
    end

    assign gnt0    = (r_state == GRANT0);
    assign gnt1    = (r_state == GRANT1);
    assign sel     = r_sel;
    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule
